// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL bring-up controller: FSM state encoding,
// retry counter width and the helper that sizes the shared cycle counter.
package pll_ctrl_pkg;

  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter serves every state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from another clock domain.
// Each bit is synchronized independently; reset value is 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      // First flop may go metastable; second flop gives it a cycle to settle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for lock with a
// timeout/retry, requires a stable lock window, then releases the core reset.
// Loss of lock in RUN restarts the whole sequence and is latched as sticky.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               core_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic               locked_s;
  pll_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pll_rst_reg, pll_rst_next;
  logic               core_rst_reg, core_rst_next;
  logic               ready_reg, ready_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               lock_lost_reg, lock_lost_next;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and registered-output decode.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    retry_next     = retry_reg;
    lock_lost_next = lock_lost_reg;

    case (state_reg)
      PLL_RST: begin
        // restart_req is deliberately ignored so the pulse always completes.
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (restart_req) begin
          state_next = PLL_RST;
        end else if (locked_s) begin
          // Lock is checked before the timeout so a coincident lock wins.
          state_next = STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = PLL_RST;
          if (retry_reg != RETRY_MAX) begin
            retry_next = retry_reg + 1'b1;
          end
        end
      end
      STABLE: begin
        if (restart_req) begin
          state_next = PLL_RST;
        end else if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = '0;
        // Lock loss takes precedence so a coincident restart still flags it.
        if (!locked_s) begin
          state_next     = PLL_RST;
          lock_lost_next = 1'b1;
        end else if (restart_req) begin
          state_next = PLL_RST;
        end
      end
      default: begin
        state_next = PLL_RST;
      end
    endcase

    if (state_next != state_reg) begin
      cnt_next = '0;
    end

    // Outputs follow the state being entered so they switch on the same edge.
    pll_rst_next  = (state_next == PLL_RST);
    core_rst_next = (state_next != RUN);
    ready_next    = (state_next == RUN);
  end

  // State, counter and output registers; rst forces the safe reset values at once.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      pll_rst_reg   <= 1'b1;
      core_rst_reg  <= 1'b1;
      ready_reg     <= 1'b0;
      retry_reg     <= '0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pll_rst_reg   <= pll_rst_next;
      core_rst_reg  <= core_rst_next;
      ready_reg     <= ready_next;
      retry_reg     <= retry_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign core_rst  = core_rst_reg;
  assign ready     = ready_reg;
  assign retry_cnt = retry_reg;
  assign lock_lost = lock_lost_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer. Stimulus pushes every expected output change
// (refclk edge number + output vector) into a queue; a monitor pops and
// compares each time the DUT outputs change. Timing convention: inputs change
// on a falling edge; the next rising edge is the first one that samples them.
module tb_pll_reset_sequencer;

  localparam int RST_C = 4;
  localparam int TO_C  = 32;
  localparam int ST_C  = 8;
  localparam logic [7:0] RESET_VEC = 8'b1100_0000;

  typedef struct {
    int         at;
    logic [7:0] vec;
  } ev_t;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_vec = RESET_VEC;
  ev_t        exp_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(ST_C)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .restart_req(restart_req),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 refclk = ~refclk;

  // Rising-edge counter: after edge n, cyc == n.
  always @(posedge refclk) cyc++;

  // Output vector layout: {pll_rst, core_rst, ready, retry_cnt[3:0], lock_lost}.
  function automatic logic [7:0] mk(input logic p, input logic c, input logic r,
                                     input logic [3:0] rc, input logic ll);
    return {p, c, r, rc, ll};
  endfunction

  function automatic logic [3:0] sat15(input int k);
    return (k > 15) ? 4'd15 : 4'(k);
  endfunction

  task automatic push(input int at, input logic [7:0] v);
    ev_t e;
    e.at  = at;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  task automatic check_now(input string name, input logic [7:0] req);
    logic [7:0] cur;
    cur = {pll_rst, core_rst, ready, retry_cnt, lock_lost};
    n_checks++;
    if (cur !== req) begin
      n_errors++;
      $display("FAIL %s: out=%b required %b (cyc=%0d)", name, cur, req, cyc);
    end else begin
      $display("check %s: out=%b ok (cyc=%0d)", name, cur, cyc);
    end
  endtask

  // Monitor: every output change must match the next queued expectation.
  always @(negedge refclk) begin : monitor
    logic [7:0] cur;
    ev_t        e;
    cur = {pll_rst, core_rst, ready, retry_cnt, lock_lost};
    if (mon_en && cur !== prev_vec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_change: cyc=%0d out=%b, required no change from %b",
                 cyc, cur, prev_vec);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.vec !== cur) begin
          n_errors++;
          $display("FAIL output_event: got cyc=%0d out=%b, required cyc=%0d out=%b",
                   cyc, cur, e.at, e.vec);
        end else begin
          $display("event cyc=%0d out=%b ok", cyc, cur);
        end
      end
    end
    prev_vec = cur;
  end

  initial begin : stimulus
    int c;
    int t0;
    int t1;
    ev_t e;

    // Reset held: all outputs at reset values.
    #1 rst = 1'b1;
    repeat (2) @(negedge refclk);
    check_now("reset_hold", RESET_VEC);
    mon_en = 1'b1;
    repeat (2) @(negedge refclk);

    // Normal bring-up: full 4-cycle pulse, lock 10 cycles after pll_rst falls,
    // ready 2 (sync) + 8 (stable) edges after the first edge sampling the lock.
    rst = 1'b0;
    c = cyc;
    push(c + RST_C, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    wait_cyc(c + RST_C + 10);
    locked = 1'b1;
    c = cyc;
    push(c + 1 + 2 + ST_C, mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0));
    wait_cyc(c + 14);

    // restart_req in RUN, second pulse inside PLL_RST, then a 1-cycle glitch
    // after 5 stable cycles forcing a fresh 8-cycle count.
    c = cyc;
    restart_req = 1'b1;
    push(c + 1, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    push(c + 5, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    push(c + 20, mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0));
    @(negedge refclk) restart_req = 1'b0;
    @(negedge refclk) restart_req = 1'b1;
    @(negedge refclk) restart_req = 1'b0;
    wait_cyc(c + 8);
    locked = 1'b0;
    @(negedge refclk) locked = 1'b1;
    wait_cyc(c + 24);

    // Lock loss in RUN with a coincident restart_req: lock-loss path wins.
    c = cyc;
    locked = 1'b0;
    push(c + 3, mk(1'b1, 1'b1, 1'b0, 4'd0, 1'b1));
    push(c + 3 + RST_C, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b1));
    wait_cyc(c + 2);
    restart_req = 1'b1;
    @(negedge refclk) restart_req = 1'b0;
    wait_cyc(c + 10);
    locked = 1'b1;
    c = cyc;
    push(c + 11, mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
    wait_cyc(c + 14);

    // Async reset asserted mid-cycle in RUN.
    @(posedge refclk);
    #2;
    push(cyc, RESET_VEC);
    rst = 1'b1;
    #1 check_now("async_reset", RESET_VEC);
    repeat (3) @(negedge refclk);

    // Timeout and retry with locked held low: saturation at 15.
    rst = 1'b0;
    locked = 1'b0;
    c = cyc;
    t0 = c + RST_C;
    push(t0, mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    for (int k = 1; k <= 17; k++) begin
      push(t0 + (RST_C + TO_C) * (k - 1) + TO_C, mk(1'b1, 1'b1, 1'b0, sat15(k), 1'b0));
      push(t0 + (RST_C + TO_C) * k, mk(1'b0, 1'b1, 1'b0, sat15(k), 1'b0));
    end
    t1 = t0 + (RST_C + TO_C) * 17;

    // Lock seen on the exact timeout edge: lock wins, no new pll_rst pulse.
    wait_cyc(t1 + TO_C - 3);
    locked = 1'b1;
    push(t1 + TO_C + ST_C, mk(1'b0, 1'b0, 1'b1, 4'd15, 1'b0));
    wait_cyc(t1 + TO_C + ST_C + 5);

    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_event: no change seen, required cyc=%0d out=%b", e.at, e.vec);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
